// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder
//   Assembles 2-byte command frames (byte0 = command code, byte1 = sensor
//   address) from the UART receive stage and validates them. Each valid frame
//   is presented as one command to the sensor controller over a valid/ready
//   handshake. The block runs in the receiver clock domain.
//
// Ports
//   clk_115200hz  in   receiver bit clock
//   rst_n         in   asynchronous reset, active low
//   data[7:0]     in   received byte, sampled only in the byte-strobe cycle
//   control       in   receiver byte-ready level; a rising edge marks a new byte
//   cmd_ready     in   sensor controller accepts the presented command
//   cmd_valid     out  command presented, held until accepted
//   cmd_code[2:0] out  validated command code
//   sensor_addr   out  validated sensor address (5 bits)
//   err_cmd       out  1-cycle pulse, illegal command code (frame discarded)
//   err_addr      out  1-cycle pulse, illegal address (frame discarded)
//   err_timeout   out  1-cycle pulse, address byte not received in time
//   err_overrun   out  1-cycle pulse, byte arrived while a command was pending
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | waiting for the command byte
// WAIT_ADDR | command byte accepted, waiting for the address byte (timed)
// ISSUE     | command presented, waiting for cmd_ready

module uart_cmd_decoder #(
   parameter int TIMEOUT_CYCLES = 11520,
   parameter int MAX_ADDR       = 31,
   parameter int MAX_CMD        = 6
) (
   input  logic       clk_115200hz,
   input  logic       rst_n,
   input  logic [7:0] data,
   input  logic       control,
   input  logic       cmd_ready,
   output logic       cmd_valid,
   output logic [2:0] cmd_code,
   output logic [4:0] sensor_addr,
   output logic       err_cmd,
   output logic       err_addr,
   output logic       err_timeout,
   output logic       err_overrun
);

   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] T_LAST     = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] T_SAT      = '1;
   localparam logic [7:0]    MAX_CMD_B  = 8'(MAX_CMD);
   localparam logic [7:0]    MAX_ADDR_B = 8'(MAX_ADDR);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_ADDR = 2'd1,
      ISSUE     = 2'd2
   } state_t;

   state_t        state;
   logic          ctl_q;
   logic          stb;
   logic [TW-1:0] timer;
   logic [2:0]    code_q;
   logic          cmd_ok;
   logic          addr_ok;

   // ctl_q resets high so a control level already high at reset release
   // is not mistaken for a new byte.
   assign stb     = control & ~ctl_q;
   assign cmd_ok  = (data <= MAX_CMD_B);
   assign addr_ok = (data <= MAX_ADDR_B);

   always_ff @(posedge clk_115200hz or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         ctl_q       <= 1'b1;
         timer       <= '0;
         code_q      <= '0;
         cmd_valid   <= 1'b0;
         cmd_code    <= '0;
         sensor_addr <= '0;
         err_cmd     <= 1'b0;
         err_addr    <= 1'b0;
         err_timeout <= 1'b0;
         err_overrun <= 1'b0;
      end else begin
         ctl_q       <= control;
         err_cmd     <= 1'b0;
         err_addr    <= 1'b0;
         err_timeout <= 1'b0;
         err_overrun <= 1'b0;

         case (state)
            IDLE: begin
               if (stb) begin
                  if (cmd_ok) begin
                     code_q <= data[2:0];
                     timer  <= '0;
                     state  <= WAIT_ADDR;
                  end else begin
                     err_cmd <= 1'b1;
                  end
               end
            end

            WAIT_ADDR: begin
               if (timer != T_SAT) begin
                  timer <= timer + TW'(1);
               end
               // A byte arriving in the expiry cycle takes priority over the timeout.
               if (stb) begin
                  if (addr_ok) begin
                     cmd_code    <= code_q;
                     sensor_addr <= data[4:0];
                     cmd_valid   <= 1'b1;
                     state       <= ISSUE;
                  end else begin
                     err_addr <= 1'b1;
                     state    <= IDLE;
                  end
               end else if (timer == T_LAST) begin
                  err_timeout <= 1'b1;
                  state       <= IDLE;
               end
            end

            ISSUE: begin
               // Any byte here is dropped, including one in the transfer cycle.
               if (stb) begin
                  err_overrun <= 1'b1;
               end
               if (cmd_ready) begin
                  cmd_valid <= 1'b0;
                  state     <= IDLE;
               end
            end

            default: begin
               cmd_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
module tb_uart_cmd_decoder;

   localparam int TO = 16;

   logic       clk_115200hz = 1'b0;
   logic       rst_n;
   logic [7:0] data;
   logic       control;
   logic       cmd_ready;
   logic       cmd_valid;
   logic [2:0] cmd_code;
   logic [4:0] sensor_addr;
   logic       err_cmd;
   logic       err_addr;
   logic       err_timeout;
   logic       err_overrun;

   int errors = 0;
   int checks = 0;
   logic [15:0] exp_q[$];

   localparam logic [3:0] K_CMD  = 4'd0;
   localparam logic [3:0] K_ECMD = 4'd1;
   localparam logic [3:0] K_EADR = 4'd2;
   localparam logic [3:0] K_ETO  = 4'd3;
   localparam logic [3:0] K_EOVR = 4'd4;

   uart_cmd_decoder #(.TIMEOUT_CYCLES(TO), .MAX_ADDR(31), .MAX_CMD(6)) dut (
      .clk_115200hz (clk_115200hz),
      .rst_n        (rst_n),
      .data         (data),
      .control      (control),
      .cmd_ready    (cmd_ready),
      .cmd_valid    (cmd_valid),
      .cmd_code     (cmd_code),
      .sensor_addr  (sensor_addr),
      .err_cmd      (err_cmd),
      .err_addr     (err_addr),
      .err_timeout  (err_timeout),
      .err_overrun  (err_overrun)
   );

   always #5 clk_115200hz = ~clk_115200hz;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] ev(input logic [3:0] kind, input logic [2:0] code,
                                      input logic [4:0] addr);
      return {kind, 1'b0, code, 3'b000, addr};
   endfunction

   task automatic observe(input logic [15:0] e);
      if (exp_q.size() == 0) chk("sb_unexpected", {16'h0, e}, 32'hFFFF);
      else                   chk("sb_event", {16'h0, e}, {16'h0, exp_q.pop_front()});
   endtask

   // Monitor: samples 1 time unit after the falling edge, well away from the
   // rising edge. A transfer is seen in the cycle where valid and ready meet.
   always begin
      @(negedge clk_115200hz);
      #1;
      if (rst_n) begin
         if (err_cmd | err_addr | err_timeout | err_overrun)
            chk("err_exclusive", 32'($countones({err_cmd, err_addr, err_timeout, err_overrun})), 1);
         if (cmd_valid && cmd_ready) observe(ev(K_CMD, cmd_code, sensor_addr));
         if (err_cmd)     observe(ev(K_ECMD, 3'd0, 5'd0));
         if (err_addr)    observe(ev(K_EADR, 3'd0, 5'd0));
         if (err_timeout) observe(ev(K_ETO, 3'd0, 5'd0));
         if (err_overrun) observe(ev(K_EOVR, 3'd0, 5'd0));
      end
   end

   initial begin
      repeat (5000) @(posedge clk_115200hz);
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // Raise control with a byte; returns one cycle after the strobe edge, control still high.
   task automatic strobe(input logic [7:0] b);
      @(negedge clk_115200hz);
      data    = b;
      control = 1'b1;
      @(negedge clk_115200hz);
   endtask

   task automatic release_ctl(input int hold);
      repeat (hold) @(negedge clk_115200hz);
      control = 1'b0;
      @(negedge clk_115200hz);
   endtask

   function automatic logic [31:0] outs();
      return {20'h0, cmd_valid, cmd_code, sensor_addr, err_cmd, err_addr, err_timeout, err_overrun};
   endfunction

   initial begin
      int n;
      rst_n     = 1'b0;
      data      = 8'h00;
      control   = 1'b0;
      cmd_ready = 1'b0;
      #1;
      chk("reset_outs", outs(), 0);
      repeat (2) @(negedge clk_115200hz);
      rst_n = 1'b1;
      @(negedge clk_115200hz);
      chk("post_reset_outs", outs(), 0);

      // 1: ready already high, one-cycle transfer
      cmd_ready = 1'b1;
      strobe(8'h01); release_ctl(1);
      exp_q.push_back(ev(K_CMD, 3'd1, 5'd5));
      strobe(8'h05);
      chk("t1_valid", {31'h0, cmd_valid}, 1);
      chk("t1_code", {29'h0, cmd_code}, 1);
      chk("t1_addr", {27'h0, sensor_addr}, 5);
      @(negedge clk_115200hz);
      chk("t1_drop", {31'h0, cmd_valid}, 0);
      release_ctl(0);

      // 2: held command under back-pressure
      cmd_ready = 1'b0;
      strobe(8'h02); release_ctl(1);
      strobe(8'h1F); release_ctl(1);
      for (int i = 0; i < 10; i++) begin
         chk("t2_hold", {24'h0, cmd_valid, cmd_code, sensor_addr}, {24'h0, 1'b1, 3'd2, 5'd31});
         @(negedge clk_115200hz);
      end
      exp_q.push_back(ev(K_CMD, 3'd2, 5'd31));
      cmd_ready = 1'b1;
      @(negedge clk_115200hz);
      chk("t2_drop", {31'h0, cmd_valid}, 0);

      // 3: illegal code, then a normal frame
      exp_q.push_back(ev(K_ECMD, 3'd0, 5'd0));
      strobe(8'h07);
      chk("t3_no_valid", {31'h0, cmd_valid}, 0);
      release_ctl(1);
      exp_q.push_back(ev(K_CMD, 3'd0, 5'd3));
      strobe(8'h00); release_ctl(1);
      strobe(8'h03); release_ctl(1);

      // 4: illegal address, then timeout latency
      exp_q.push_back(ev(K_EADR, 3'd0, 5'd0));
      strobe(8'h03); release_ctl(1);
      strobe(8'h20);
      chk("t4_no_valid", {31'h0, cmd_valid}, 0);
      release_ctl(1);
      exp_q.push_back(ev(K_ETO, 3'd0, 5'd0));
      strobe(8'h03);
      n = 0;
      while (!err_timeout && n < 40) begin
         @(negedge clk_115200hz);
         n++;
      end
      chk("t4_timeout_lat", 32'(n), TO);
      release_ctl(0);

      // 5: long control level is a single byte; overrun during ISSUE
      strobe(8'h04); release_ctl(1);
      exp_q.push_back(ev(K_CMD, 3'd4, 5'd6));
      strobe(8'h06); release_ctl(19);
      cmd_ready = 1'b0;
      strobe(8'h03); release_ctl(1);
      strobe(8'h09); release_ctl(1);
      exp_q.push_back(ev(K_EOVR, 3'd0, 5'd0));
      strobe(8'h11); release_ctl(1);
      chk("t5_intact", {24'h0, cmd_valid, cmd_code, sensor_addr}, {24'h0, 1'b1, 3'd3, 5'd9});
      // byte in the transfer cycle is also dropped
      exp_q.push_back(ev(K_CMD, 3'd3, 5'd9));
      exp_q.push_back(ev(K_EOVR, 3'd0, 5'd0));
      data      = 8'h05;
      control   = 1'b1;
      cmd_ready = 1'b1;
      @(negedge clk_115200hz);
      chk("t5_drop", {31'h0, cmd_valid}, 0);
      release_ctl(1);

      // 6: async reset in ISSUE and in WAIT_ADDR
      cmd_ready = 1'b0;
      strobe(8'h06); release_ctl(1);
      strobe(8'h0A); release_ctl(1);
      chk("t6_pending", {31'h0, cmd_valid}, 1);
      #2 rst_n = 1'b0;
      #1 chk("t6_issue_rst", outs(), 0);
      @(negedge clk_115200hz);
      rst_n = 1'b1;
      strobe(8'h04); release_ctl(1);
      #2 rst_n = 1'b0;
      #1 chk("t6_wait_rst", outs(), 0);
      @(negedge clk_115200hz);
      rst_n = 1'b1;
      repeat (TO + 4) @(negedge clk_115200hz);
      chk("t6_quiet", outs(), 0);
      cmd_ready = 1'b1;
      exp_q.push_back(ev(K_CMD, 3'd4, 5'd1));
      strobe(8'h04); release_ctl(1);
      strobe(8'h01);
      chk("t6_after", {24'h0, cmd_valid, cmd_code, sensor_addr}, {24'h0, 1'b1, 3'd4, 5'd1});
      release_ctl(1);

      repeat (5) @(negedge clk_115200hz);
      chk("sb_empty", 32'(exp_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
